// File: rtl/mem_bus_ctrl.sv
// Memory bus controller: turns MAR/MDR read/write requests into a wait-stated req/ack access.
// Optional MEM_TIMEOUT_EN aborts an unacknowledged access after TIMEOUT_CYCLES with err set.
`timescale 1ns/1ps
module mem_bus_ctrl #(
    parameter int WAIT_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic [15:0] MAR_in,
    input  logic [15:0] MDR_in,
    input  logic        RD_req,
    input  logic        WR_req,
    output logic [15:0] M_bus_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 ||
        TIMEOUT_CYCLES <= WAIT_CYCLES || TIMEOUT_CYCLES > 16) begin : g_bad_params
        $error("mem_bus_ctrl: WAIT_CYCLES must be 1..15 and below TIMEOUT_CYCLES (max 16)");
    end

    state_t      state;
    state_t      next_state;
    logic        op_write;
    logic [3:0]  wait_cnt;
    logic        start_wr;
    logic        start_rd;
    logic        ack_exit;

`ifdef MEM_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT_CYCLES - 1);
    logic        timeout_exit;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Write has priority over read when both requests arrive together.
    always_comb begin
        next_state = state;
        start_wr   = 1'b0;
        start_rd   = 1'b0;
        ack_exit   = 1'b0;
`ifdef MEM_TIMEOUT_EN
        timeout_exit = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (WR_req) begin
                    start_wr   = 1'b1;
                    next_state = SETUP;
                end else if (RD_req) begin
                    start_rd   = 1'b1;
                    next_state = SETUP;
                end
            end
            SETUP:  next_state = ACCESS;
            ACCESS: begin
                if (wait_cnt >= WAIT_LAST && mem_ack) begin
                    ack_exit   = 1'b1;
                    next_state = DONE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (wait_cnt == TIMEOUT_LAST) begin
                    timeout_exit = 1'b1;
                    next_state   = DONE;
                end
`endif
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Strobes are registered off next_state so they stay glitch-free for all of ACCESS.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            op_write   <= 1'b0;
            wait_cnt   <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            M_bus_data <= '0;
        end else begin
            if (start_wr || start_rd) begin
                mem_addr <= MAR_in;
                op_write <= start_wr;
                if (start_wr) begin
                    mem_wdata <= MDR_in;
                end
            end
            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if (state == ACCESS && wait_cnt != 4'hF) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            mem_re <= (next_state == ACCESS) && !op_write;
            mem_we <= (next_state == ACCESS) && op_write;
            if (ack_exit && !op_write) begin
                M_bus_data <= mem_rdata;
            end
`ifdef MEM_TIMEOUT_EN
            if (timeout_exit && !op_write) begin
                M_bus_data <= 16'hFFFF;
            end
`endif
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            err <= 1'b0;
        end else if (start_wr || start_rd) begin
            err <= 1'b0;
        end else if (timeout_exit) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side stage directly downstream of the datapath and upstream of its M bus input.
- Takes MAR address, MDR write data and read/write strobes from the microsequencer.
- Runs a wait-stated request/acknowledge cycle to external memory.
- Returns read data, held stable, onto the datapath M-bus input for the MMD load.

Parameters:
- WAIT_CYCLES, 2: minimum cycles spent in ACCESS, range 1..15.
- TIMEOUT_CYCLES, 15: ACCESS cycles before abort; used only with MEM_TIMEOUT_EN; must be greater than WAIT_CYCLES.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  reset. Asynchronous, active-low.
- MAR_in  in  16  address from datapath MAR output.
- MDR_in  in  16  write data from datapath MDR-to-M output.
- RD_req  in  1  read request, level, from sequencer.
- WR_req  in  1  write request, level, from sequencer.
- M_bus_data  out  16  read data to datapath M_bus_in.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  timeout error flag.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_re  out  1  memory read strobe.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  16  memory read data.
- mem_ack  in  1  memory acknowledge.

Behaviour:
- Reset (CLR=0, async, any state): state=IDLE; all outputs 0, including M_bus_data, mem_addr, mem_wdata, err; counters 0.
- Strobe release: mem_re and mem_we drop immediately on reset, with no clock needed. Mid-transaction reset abandons the access; no done pulse is issued.
- FSM states: IDLE, SETUP, ACCESS, DONE (2-bit encoding).
- IDLE:
  - busy=0.
  - At an edge with WR_req=1: latch mem_addr<=MAR_in, mem_wdata<=MDR_in, op=write; go to SETUP.
  - Else at an edge with RD_req=1: latch mem_addr<=MAR_in, op=read; go to SETUP.
  - RD_req and WR_req both 1: write wins. The read is dropped and not queued.
- SETUP:
  - One cycle, busy=1, strobes 0 (address setup). Clear wait_cnt.
  - Next state: ACCESS.
- ACCESS:
  - busy=1. mem_re=op_read, mem_we=op_write; strobes are registered and stable for the whole state.
  - wait_cnt increments each edge, saturating at 15.
  - Exit to DONE at the first edge where wait_cnt >= WAIT_CYCLES-1 and mem_ack=1.
  - A read captures M_bus_data<=mem_rdata on that same edge.
  - mem_ack during the first WAIT_CYCLES-1 cycles is ignored.
- DONE:
  - One cycle, done=1, busy=1, strobes 0.
  - Next state: IDLE unconditionally.
- Requests are sampled only in IDLE. Requests asserted while busy=1 are ignored; the sequencer must hold or reassert them.
- A request still high in the IDLE cycle after DONE starts a new transaction (back-to-back allowed).
- Latency with ack already high: request sampled at edge E gives SETUP at E+1, ACCESS E+1..E+1+WAIT_CYCLES, done high in the cycle after edge E+1+WAIT_CYCLES.
- M_bus_data holds the last read value until the next successful read completes. Writes never alter it.
- err:
  - Set on timeout (see Optional Feature).
  - Cleared at the start of the next transaction, on the IDLE→SETUP edge.
- mem_addr and mem_wdata hold their last latched values in IDLE.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - If ACCESS reaches wait_cnt == TIMEOUT_CYCLES-1 with no ack, go to DONE with err<=1.
  - For a read, M_bus_data<=16'hFFFF.
  - done pulses normally.
- Undefined:
  - ACCESS waits indefinitely for mem_ack.
  - err is tied to 0.
  - No timeout counter logic is synthesised.

Test Plan:
- Reset: drive CLR=0 mid-ACCESS of a read → mem_re falls within the same cycle; all outputs are 0; no done pulse; state is IDLE after CLR=1.
- Read, WAIT_CYCLES=2, mem_ack tied 1: MAR_in=16'h0040, mem_rdata=16'hBEEF, RD_req pulsed at edge 0 → mem_re=1 after edges 1–2 only; done=1 in the cycle after edge 3; M_bus_data=16'hBEEF held through a following write.
- Write with late ack: MAR_in=16'h00C0, MDR_in=16'h1234, ack arrives 5 cycles into ACCESS → mem_we held high 5 cycles with mem_addr=16'h00C0 and mem_wdata=16'h1234 stable; done pulses once; M_bus_data unchanged.
- Simultaneous requests: RD_req=WR_req=1 in one cycle → a single write transaction only; exactly one done pulse.
- Busy ignore and back-to-back: RD_req raised during ACCESS → ignored. RD_req held through DONE → second read starts from IDLE with no lost or extra cycles.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=15, mem_ack=0 on a read → done after 15 ACCESS cycles; err=1; M_bus_data=16'hFFFF. err clears on the next SETUP.
